// File: rtl/otter_sb_pkg.sv
// otter_sb_pkg: shared types and sizing for the OTTER writer-side scoreboard.
//   NUM_REGS   - architectural register count (x0..x31)
//   reg_addr_t - register address type
//   inflight_w - width of the total in-flight counter for a given per-register counter width
package otter_sb_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    // Sized for the true worst case: 31 trackable registers each holding the maximum count.
    // Never narrower than 6 bits.
    function automatic int inflight_w(input int cnt_w);
        int worst;
        int w;
        worst = (NUM_REGS - 1) * ((1 << cnt_w) - 1);
        w     = $clog2(worst + 1);
        return (w < 6) ? 6 : w;
    endfunction

endpackage

// File: rtl/otter_scoreboard_entry.sv
// sb_entry: pending-write counter for one architectural register.
//   clk, rst_n      - clock, async active-low reset
//   inc, dec, flush - add one issue, retire one writeback, clear (flush wins)
//   count           - current pending-write count
//   pending         - count != 0
//   at_max          - count is saturated (no further issue to this register)
//   is_one          - exactly one write outstanding (used by the writeback bypass)
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             pending,
    output logic             at_max,
    output logic             is_one
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] count_q, count_d;

    // inc and dec together cancel. The range guards keep the counter from wrapping
    // even if a caller asks for something it should not.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec && count_q != MAX_CNT) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign pending = (count_q != '0);
    assign at_max  = (count_q == MAX_CNT);
    assign is_one  = (count_q == CNT_W'(1));

endmodule

// File: rtl/otter_scoreboard.sv
// otter_scoreboard: tracks in-flight destination registers from issue to writeback and
// tells decode whether the presented instruction may issue.
//   CLK, RST_N                  - clock, async active-low reset
//   ISSUE_VALID/RD/RF_WE        - instruction at decode and its destination
//   ISSUE_RS1/RS2, USE_RS1/RS2  - its sources and whether each is read
//   ISSUE_READY                 - combinational issue permission (ignores ISSUE_VALID)
//   WB_VALID, WB_RD             - writeback retiring a register write
//   FLUSH                       - drop all pending state next edge
//   PENDING                     - per-register pending flags (x0 always 0)
//   INFLIGHT                    - total pending writes
//   SB_ERR                      - sticky: writeback to a register with no pending write
module otter_scoreboard
    import otter_sb_pkg::*;
#(
    parameter  int CNT_W     = 2,
    parameter  int WB_BYPASS = 1,
    localparam int IFW       = inflight_w(CNT_W)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ISSUE_VALID,
    input  reg_addr_t           ISSUE_RD,
    input  logic                ISSUE_RF_WE,
    input  reg_addr_t           ISSUE_RS1,
    input  reg_addr_t           ISSUE_RS2,
    input  logic                ISSUE_USE_RS1,
    input  logic                ISSUE_USE_RS2,
    output logic                ISSUE_READY,
    input  logic                WB_VALID,
    input  reg_addr_t           WB_RD,
    input  logic                FLUSH,
    output logic [NUM_REGS-1:0] PENDING,
    output logic [IFW-1:0]      INFLIGHT,
    output logic                SB_ERR
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            pend, at_max, is_one;
    logic [NUM_REGS-1:0]            inc_v, dec_v;
    logic                           hz_rs1, hz_rs2, struct_stall, accept, wb_err;
    logic [IFW-1:0]                 inflight_q, inflight_d;
    logic                           err_q, err_d;

    // x0 has no entry; tie its slot so it never reports pending.
    assign cnt[0]    = '0;
    assign pend[0]   = 1'b0;
    assign at_max[0] = 1'b0;
    assign is_one[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk     (CLK),
            .rst_n   (RST_N),
            .inc     (inc_v[r]),
            .dec     (dec_v[r]),
            .flush   (FLUSH),
            .count   (cnt[r]),
            .pending (pend[r]),
            .at_max  (at_max[r]),
            .is_one  (is_one[r])
        );
    end

    // A source whose last outstanding write retires this cycle can be forwarded, so
    // with the bypass enabled it is not a hazard.
    always_comb begin
        hz_rs1 = ISSUE_USE_RS1 && (ISSUE_RS1 != '0) && pend[ISSUE_RS1] &&
                 !((WB_BYPASS != 0) && WB_VALID && (WB_RD == ISSUE_RS1) && is_one[ISSUE_RS1]);
        hz_rs2 = ISSUE_USE_RS2 && (ISSUE_RS2 != '0) && pend[ISSUE_RS2] &&
                 !((WB_BYPASS != 0) && WB_VALID && (WB_RD == ISSUE_RS2) && is_one[ISSUE_RS2]);
        // A saturated destination can still take an issue when a writeback to it frees a slot.
        struct_stall = ISSUE_RF_WE && (ISSUE_RD != '0) && at_max[ISSUE_RD] &&
                       !(WB_VALID && (WB_RD == ISSUE_RD));
    end

    assign ISSUE_READY = !(hz_rs1 || hz_rs2 || struct_stall);
    assign accept      = ISSUE_VALID && ISSUE_READY;

    // One-hot increment/decrement vectors; bit 0 masked so x0 is never tracked.
    // A writeback only retires a write that existed before this edge.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (accept && ISSUE_RF_WE) begin
            inc_v = NUM_REGS'(1) << ISSUE_RD;
        end
        if (WB_VALID) begin
            dec_v = (NUM_REGS'(1) << WB_RD) & pend;
        end
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
    end

    assign wb_err = WB_VALID && (WB_RD != '0) && !pend[WB_RD];

    // The total tracks the same inc/dec the entries apply, so it stays a true register.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (FLUSH) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q + IFW'(|inc_v) - IFW'(|dec_v);
            err_d      = err_q || wb_err;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign PENDING  = pend;
    assign INFLIGHT = inflight_q;
    assign SB_ERR   = err_q;

endmodule

// File: tb/tb_otter_scoreboard.sv
// Bench for otter_scoreboard: two instances share stimulus, index 0 with the writeback
// bypass and index 1 without. A count-per-register model predicts both.
module tb_otter_scoreboard;
    import otter_sb_pkg::*;

    localparam int CNT_W = 2;
    localparam int IFW   = inflight_w(CNT_W);
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic       clk, rst_n;
    logic       iss_valid, iss_we, iss_u1, iss_u2, wb_valid, flush;
    logic [4:0] iss_rd, iss_rs1, iss_rs2, wb_rd;
    logic           rdy  [2];
    logic [31:0]    pend [2];
    logic [IFW-1:0] infl [2];
    logic           err  [2];

    int m_cnt [2][32];
    bit m_err [2];
    int vectors, miscompares;

    otter_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1)) dut (
        .CLK(clk), .RST_N(rst_n), .ISSUE_VALID(iss_valid), .ISSUE_RD(iss_rd),
        .ISSUE_RF_WE(iss_we), .ISSUE_RS1(iss_rs1), .ISSUE_RS2(iss_rs2),
        .ISSUE_USE_RS1(iss_u1), .ISSUE_USE_RS2(iss_u2), .ISSUE_READY(rdy[0]),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .FLUSH(flush),
        .PENDING(pend[0]), .INFLIGHT(infl[0]), .SB_ERR(err[0]));

    otter_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(0)) dut_nb (
        .CLK(clk), .RST_N(rst_n), .ISSUE_VALID(iss_valid), .ISSUE_RD(iss_rd),
        .ISSUE_RF_WE(iss_we), .ISSUE_RS1(iss_rs1), .ISSUE_RS2(iss_rs2),
        .ISSUE_USE_RS1(iss_u1), .ISSUE_USE_RS2(iss_u2), .ISSUE_READY(rdy[1]),
        .WB_VALID(wb_valid), .WB_RD(wb_rd), .FLUSH(flush),
        .PENDING(pend[1]), .INFLIGHT(infl[1]), .SB_ERR(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_hazard(int b, logic [4:0] s, bit used);
        if (!used || s == 0 || m_cnt[b][s] == 0) return 1'b0;
        if (b == 0 && wb_valid && wb_rd == s && m_cnt[b][s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready(int b);
        bit st;
        st = iss_we && iss_rd != 0 && m_cnt[b][iss_rd] == MAXC && !(wb_valid && wb_rd == iss_rd);
        return !(m_hazard(b, iss_rs1, iss_u1) || m_hazard(b, iss_rs2, iss_u2) || st);
    endfunction

    function automatic logic [31:0] m_pend(int b);
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (m_cnt[b][r] != 0);
        return v;
    endfunction

    function automatic logic [IFW-1:0] m_sum(int b);
        int s = 0;
        for (int r = 1; r < 32; r++) s += m_cnt[b][r];
        return IFW'(s);
    endfunction

    task automatic m_clear();
        for (int b = 0; b < 2; b++) begin
            m_err[b] = 1'b0;
            for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        iss_valid = 0; iss_rd = 0; iss_we = 0; iss_rs1 = 0; iss_rs2 = 0;
        iss_u1 = 0; iss_u2 = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic set_issue(bit v, logic [4:0] rd, bit we, logic [4:0] rs1, bit u1,
                             logic [4:0] rs2, bit u2);
        iss_valid = v; iss_rd = rd; iss_we = we;
        iss_rs1 = rs1; iss_u1 = u1; iss_rs2 = rs2; iss_u2 = u2;
    endtask

    task automatic set_wb(bit v, logic [4:0] rd);
        wb_valid = v; wb_rd = rd;
    endtask

    // Advance one clock from a negedge, applying the current inputs to the model.
    task automatic step();
        bit acc [2];
        for (int b = 0; b < 2; b++) acc[b] = iss_valid && m_ready(b);
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (flush) begin
                for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
            end else begin
                if (wb_valid && wb_rd != 0) begin
                    if (m_cnt[b][wb_rd] == 0) m_err[b] = 1'b1;
                    else m_cnt[b][wb_rd]--;
                end
                if (acc[b] && iss_we && iss_rd != 0) m_cnt[b][iss_rd]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pend[b] !== 32'h0 || infl[b] !== '0 || err[b] !== 1'b0 || rdy[b] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: pend=%h infl=%0d err=%b rdy=%b, want 0/0/0/1",
                         b, pend[b], infl[b], err[b], rdy[b]);
            end
        end
        // Build count[5]=2 and a sticky error, then pull reset between edges.
        set_issue(1, 5, 1, 0, 0, 0, 0); step(); step();
        set_issue(0, 0, 0, 0, 0, 0, 0); set_wb(1, 12); step(); set_wb(0, 0);
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (infl[b] !== IFW'(2) || pend[b] !== 32'h20 || err[b] !== 1'b1) begin
                miscompares++;
                $display("FAIL pre_reset dut%0d: infl=%0d pend=%h err=%b, want 2/00000020/1",
                         b, infl[b], pend[b], err[b]);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pend[b] !== 32'h0 || infl[b] !== '0 || err[b] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: pend=%h infl=%0d err=%b, want 0",
                         b, pend[b], infl[b], err[b]);
            end
        end
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_raw_stall();
        do_reset();
        set_issue(1, 5, 1, 0, 0, 0, 0); step();
        set_issue(1, 6, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (rdy[b] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL raw_stall dut%0d cyc%0d: ready=%b want 0", b, i, rdy[b]);
                end
            end
            step();
        end
        set_wb(1, 5);
        #1;
        vectors++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_wb_cycle: ready byp=%b nobyp=%b, want 1/0", rdy[0], rdy[1]);
        end
        step();
        set_wb(0, 0);
        #1;
        vectors++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1 || infl[0] !== IFW'(1) || infl[1] !== '0) begin
            miscompares++;
            $display("FAIL raw_after_wb: ready=%b/%b infl=%0d/%0d, want 1/1 1/0",
                     rdy[0], rdy[1], infl[0], infl[1]);
        end
        step();
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        set_issue(1, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL x0_ready cyc%0d: ready=%b/%b want 1/1", i, rdy[0], rdy[1]);
            end
            if (i == 9) set_wb(1, 0);
            step();
        end
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (infl[b] !== '0 || pend[b] !== 32'h0 || err[b] !== 1'b0) begin
                miscompares++;
                $display("FAIL x0_untracked dut%0d: infl=%0d pend=%h err=%b, want 0",
                         b, infl[b], pend[b], err[b]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_issue(1, 7, 1, 0, 0, 0, 0);
        step(); step(); step();
        #1;
        vectors++;
        if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0 || infl[0] !== IFW'(3)) begin
            miscompares++;
            $display("FAIL sat_stall: ready=%b/%b infl=%0d, want 0/0 3", rdy[0], rdy[1], infl[0]);
        end
        step();
        set_wb(1, 7);
        #1;
        vectors++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_wb_ready: ready=%b/%b want 1/1", rdy[0], rdy[1]);
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (infl[b] !== IFW'(3) || pend[b] !== 32'h80 || err[b] !== 1'b0) begin
                miscompares++;
                $display("FAIL sat_count dut%0d: infl=%0d pend=%h err=%b, want 3/00000080/0",
                         b, infl[b], pend[b], err[b]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_issue(1, 9, 1, 0, 0, 0, 0); step();
        set_wb(1, 9); step();
        set_issue(0, 0, 0, 0, 0, 0, 0); set_wb(0, 0);
        #1;
        vectors++;
        if (pend[0][9] !== 1'b1 || infl[0] !== IFW'(1) || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_nonzero: pend9=%b infl=%0d err=%b, want 1/1/0",
                     pend[0][9], infl[0], err[0]);
        end
        // Issue plus writeback to a zero-count register: the issue counts, the WB is an error.
        set_issue(1, 10, 1, 0, 0, 0, 0); set_wb(1, 10); step();
        idle();
        #1;
        vectors++;
        if (pend[0][10] !== 1'b1 || infl[0] !== IFW'(2) || err[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_zero: pend10=%b infl=%0d err=%b, want 1/2/1",
                     pend[0][10], infl[0], err[0]);
        end
    endtask

    task automatic test_error_flush();
        do_reset();
        set_wb(1, 12); step(); set_wb(0, 0); step(); step();
        #1;
        vectors++;
        if (err[0] !== 1'b1 || err[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b/%b want 1/1", err[0], err[1]);
        end
        set_issue(1, 3, 1, 0, 0, 0, 0); step();
        set_issue(1, 4, 1, 0, 0, 0, 0); step(); step();
        set_issue(1, 8, 1, 0, 0, 0, 0); set_wb(1, 3); flush = 1'b1;
        #1;
        vectors++;
        if (infl[0] !== IFW'(3) || pend[0] !== 32'h18) begin
            miscompares++;
            $display("FAIL pre_flush: infl=%0d pend=%h want 3/00000018", infl[0], pend[0]);
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pend[b] !== 32'h0 || infl[b] !== '0 || err[b] !== 1'b1) begin
                miscompares++;
                $display("FAIL flush dut%0d: pend=%h infl=%0d err=%b, want 0/0/1",
                         b, pend[b], infl[b], err[b]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_issue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
                      5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                      5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            set_wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 60) == 0);
            #1;
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (rdy[b] !== m_ready(b) || pend[b] !== m_pend(b) ||
                    infl[b] !== m_sum(b) || err[b] !== m_err[b]) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: rdy=%b/%b pend=%h/%h infl=%0d/%0d err=%b/%b (got/want)",
                             b, c, rdy[b], m_ready(b), pend[b], m_pend(b),
                             infl[b], m_sum(b), err[b], m_err[b]);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        idle();
        m_clear();
        test_reset();
        test_raw_stall();
        test_x0();
        test_saturation();
        test_simultaneous();
        test_error_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
